// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds one even-parity bit per frame).
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Cycles from the first START cycle to the end of the STOP cycle.
  function automatic int frame_len(input int width);
`ifdef SERIAL_TX_PARITY_EN
    return width + 3;
`else
    return width + 2;
`endif
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Parallel word handshake into the serial transmitter.
// The source drives D/in_valid and must hold the word until in_ready is seen.
interface serial_tx_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] D;
  logic             in_valid;
  logic             in_ready;

  // Word source side.
  modport master (
    output D,
    output in_valid,
    input  in_ready
  );

  // Transmitter side.
  modport slave (
    input  D,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/dff_async.sv
// Output flop with asynchronous active-high reset and a complementary output.
// not_Q is derived from the same storage bit, so it can never disagree with Q,
// including while reset is asserted.
module dff_async (
  input  logic D,
  input  logic clk,
  input  logic reset,
  output logic Q,
  output logic not_Q
);

  logic q_r;

  // Line register: cleared the instant reset rises, no clock needed.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) q_r <= 1'b0;
    else       q_r <= D;
  end

  assign Q     = q_r;
  assign not_Q = ~q_r;

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter, LSB first, framed as
//   START(1) | WIDTH data bits | [PARITY] | STOP(0)
// Q always shows the bit belonging to the current state, so the line value is
// computed from the next state and registered in dff_async.
// Optional feature macro: SERIAL_TX_PARITY_EN (even parity bit before STOP).
module serial_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  serial_tx_if.slave        in_if,
  output logic              Q,
  output logic              not_Q,
  output logic              busy,
  output logic              frame_done
);

  import serial_pkg::*;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             line_d;
  logic             accept;

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  // A new word may enter from IDLE or from STOP (back-to-back frames).
  assign in_if.in_ready = (state_q == IDLE) || (state_q == STOP);
  assign accept         = in_if.in_valid && in_if.in_ready;

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP);

  // State, shift register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      // NOTE: the shift register is a plain datapath register, not a memory
      // array, so it is reset cheaply; no stale word can leak after a reset.
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Even parity of the latched word, captured at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
`endif

  // Next-state, datapath and next line value.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    line_d  = LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shreg_d = in_if.D;
          line_d  = START_BIT;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^in_if.D;
`endif
        end
      end

      START: begin
        state_d = DATA;
        line_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
        cnt_d   = '0;
      end

      DATA: begin
        if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = PARITY;
          line_d  = parity_q;
`else
          state_d = STOP;
          line_d  = STOP_BIT;
`endif
        end else begin
          line_d  = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        state_d = STOP;
        line_d  = STOP_BIT;
      end
`endif

      STOP: begin
        if (accept) begin
          state_d = START;
          shreg_d = in_if.D;
          line_d  = START_BIT;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^in_if.D;
`endif
        end else begin
          state_d = IDLE;
          line_d  = LINE_IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        line_d  = LINE_IDLE;
      end
    endcase
  end

  dff_async u_line (
    .D     (line_d),
    .clk   (clk),
    .reset (reset),
    .Q     (Q),
    .not_Q (not_Q)
  );

endmodule

// File: tb/tb_serial_tx.sv
// Directed testbench for serial_tx. Build with +define+SERIAL_TX_PARITY_EN to
// exercise the parity variant.
module tb_serial_tx;

  localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FLEN = W + 3;
`else
  localparam int FLEN = W + 2;
`endif

  logic clk = 1'b0;
  logic reset;
  logic q, not_q, busy, frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  serial_tx_if #(.WIDTH(W)) bus ();

  serial_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (bus.slave),
    .Q          (q),
    .not_Q      (not_q),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line bits, index k = k-th cycle after the acceptance edge.
  function automatic logic [31:0] model_frame(input logic [W-1:0] w);
    logic [31:0] f;
    f    = '0;
    f[0] = 1'b1;
    for (int i = 0; i < W; i++) f[i+1] = w[i];
`ifdef SERIAL_TX_PARITY_EN
    f[W+1] = ^w;
`endif
    return f;
  endfunction

  task automatic accept_word(input logic [W-1:0] w);
    bus.D        = w;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Record n cycles of the line; optionally drive D/in_valid at cycle mid_k
  // (in_valid is dropped again one cycle later).
  task automatic capture(input logic [31:0] exp, input int n, input int mid_k,
                         input logic [W-1:0] mid_d, input logic mid_v,
                         output logic [31:0] obs, output int busy_n,
                         output int done_n, output int done_at, output int notq_bad);
    obs = '0; busy_n = 0; done_n = 0; done_at = -1; notq_bad = 0;
    for (int k = 0; k < n; k++) begin
      obs[k] = q;
      if (busy) busy_n++;
      if (frame_done) begin done_n++; done_at = k; end
      if (not_q !== ~exp[k]) notq_bad++;
      if (k == mid_k) begin bus.D = mid_d; bus.in_valid = mid_v; end
      if (k == mid_k + 1) bus.in_valid = 1'b0;
      tick();
    end
  endtask

  logic [31:0] obs, exp;
  int busy_n, done_n, done_at, notq_bad, ones;

  initial begin
    reset        = 1'b1;
    bus.D        = '0;
    bus.in_valid = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_q",        q,            1'b0);
    check("rst_not_q",    not_q,        1'b1);
    check("rst_busy",     busy,         1'b0);
    check("rst_done",     frame_done,   1'b0);
    check("rst_ready",    bus.in_ready, 1'b1);
    reset = 1'b0;
    tick();
    check("idle_q",       q,            1'b0);

    // Single frame 0xA5.
    accept_word(8'hA5);
    exp = model_frame(8'hA5);
    capture(exp, FLEN, -1, '0, 1'b0, obs, busy_n, done_n, done_at, notq_bad);
    check("a5_start",     obs[0],       1'b1);
    check("a5_data",      obs[W:1],     8'hA5);
    check("a5_stop",      obs[FLEN-1],  1'b0);
    check("a5_frame",     obs,          exp);
    check("a5_busy_n",    busy_n,       FLEN);
    check("a5_done_n",    done_n,       1);
    check("a5_done_at",   done_at,      FLEN - 1);
    check("a5_notq",      notq_bad,     0);
    check("a5_post_busy", busy,         1'b0);
    check("a5_post_q",    q,            1'b0);
`ifdef SERIAL_TX_PARITY_EN
    check("a5_parity",    obs[W+1],     1'b0);
`endif

    // Back-to-back 0x01 then 0x80 with in_valid held.
    accept_word(8'h01);
    bus.D        = 8'h80;
    bus.in_valid = 1'b1;
    exp = (model_frame(8'h80) << FLEN) | model_frame(8'h01);
    capture(exp, 2 * FLEN, FLEN - 1, 8'h80, 1'b1, obs, busy_n, done_n, done_at, notq_bad);
    check("b2b_frames",   obs,          exp);
    check("b2b_busy_n",   busy_n,       2 * FLEN);
    check("b2b_done_n",   done_n,       2);
    check("b2b_2nd_strt", obs[FLEN],    1'b1);
    check("b2b_notq",     notq_bad,     0);
    check("b2b_post",     busy,         1'b0);

    // D changes right after acceptance of 0x3C.
    accept_word(8'h3C);
    exp = model_frame(8'h3C);
    capture(exp, FLEN, 0, 8'hFF, 1'b0, obs, busy_n, done_n, done_at, notq_bad);
    check("chg_data",     obs[W:1],     8'h3C);
    check("chg_frame",    obs,          exp);

    // in_valid with 0x55 while in DATA is ignored.
    accept_word(8'h0F);
    exp = model_frame(8'h0F);
    capture(exp, FLEN, 3, 8'h55, 1'b1, obs, busy_n, done_n, done_at, notq_bad);
    check("ign_frame",    obs,          exp);
    ones = 0; busy_n = 0;
    for (int k = 0; k < FLEN; k++) begin
      if (q) ones++;
      if (busy) busy_n++;
      tick();
    end
    check("ign_ones",     ones,         0);
    check("ign_busy",     busy_n,       0);

`ifdef SERIAL_TX_PARITY_EN
    // Parity of 0x07 is 1.
    accept_word(8'h07);
    exp = model_frame(8'h07);
    capture(exp, FLEN, -1, '0, 1'b0, obs, busy_n, done_n, done_at, notq_bad);
    check("p07_parity",   obs[W+1],     1'b1);
    check("p07_busy_n",   busy_n,       11);
    check("p07_frame",    obs,          exp);
`endif

    // Reset during DATA bit 3 of 0xFF.
    accept_word(8'hFF);
    repeat (4) tick();
    check("mid_pre_q",    q,            1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_q",        q,            1'b0);
    check("mid_not_q",    not_q,        1'b1);
    check("mid_busy",     busy,         1'b0);
    check("mid_done",     frame_done,   1'b0);
    tick();
    tick();
    reset = 1'b0;
    check("mid_ready",    bus.in_ready, 1'b1);
    ones = 0; busy_n = 0;
    for (int k = 0; k < 2 * FLEN; k++) begin
      if (q) ones++;
      if (busy) busy_n++;
      tick();
    end
    check("mid_ones",     ones,         0);
    check("mid_busy_n",   busy_n,       0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
